// File: rtl/ss_sort_pkg.sv
// Shared types and defaults for the bubble-sort controller and its datapath.
package ss_sort_pkg;

   localparam int SS_SORT_N = 16;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_READ,
      ST_WAIT,
      ST_CMP,
      ST_SWAP,
      ST_NEXT,
      ST_DONE
   } sort_state_t;

endpackage

// File: rtl/SS_detect_edge.sv
// Two-flop edge detector: o_edge pulses for one cycle on the selected edge of i_sig.
module SS_detect_edge #(
   parameter bit POS_EDGE = 1'b1
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_sig,
   output logic o_edge
);

   logic sig_q0;
   logic sig_q1;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         sig_q0 <= 1'b0;
         sig_q1 <= 1'b0;
      end else begin
         sig_q0 <= i_sig;
         sig_q1 <= sig_q0;
      end
   end

   assign o_edge = POS_EDGE ? (sig_q0 & ~sig_q1) : (~sig_q0 & sig_q1);

endmodule

// File: rtl/ss_sort_ctrl.sv
// Bubble-sort sequencer: walks adjacent pairs, asks the datapath to swap when
// mem[a] > mem[b], shrinking the pass window until a pass makes no swap.
module ss_sort_ctrl
   import ss_sort_pkg::*;
#(
   parameter int N  = SS_SORT_N,
   parameter int AW = $clog2(N)
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic          i_start,
   input  logic          i_abort,
   input  logic          i_gt,
   output logic          o_rd_en,
   output logic [AW-1:0] o_addr_a,
   output logic [AW-1:0] o_addr_b,
   output logic          o_swap_we,
   output logic          o_busy,
   output logic          o_done,
   output logic [15:0]   o_swap_cnt
);

   localparam logic [AW-1:0] LIMIT_INIT = AW'(N - 1);

   sort_state_t   state;
   sort_state_t   state_nxt;
   logic [AW-1:0] idx;
   logic [AW-1:0] limit;
   logic          swapped;
   logic          start_edge;
   logic          pass_end;
   logic          run_end;

   SS_detect_edge #(
      .POS_EDGE (1'b1)
   ) u_start_edge (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_sig   (i_start),
      .o_edge  (start_edge)
   );

   assign pass_end = (idx == limit - AW'(1));
   assign run_end  = !swapped || (limit == AW'(1));

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      if (i_abort) begin
         state_nxt = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE: if (start_edge) state_nxt = ST_READ;
            ST_READ: state_nxt = ST_WAIT;
            ST_WAIT: state_nxt = ST_CMP;
            ST_CMP:  state_nxt = i_gt ? ST_SWAP : ST_NEXT;
            ST_SWAP: state_nxt = ST_NEXT;
            ST_NEXT: state_nxt = (pass_end && run_end) ? ST_DONE : ST_READ;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
         endcase
      end
   end

   // Loop bookkeeping; an abort freezes everything including the swap count.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         idx        <= '0;
         limit      <= LIMIT_INIT;
         swapped    <= 1'b0;
         o_swap_cnt <= '0;
      end else if (!i_abort) begin
         case (state)
            ST_IDLE: begin
               if (start_edge) begin
                  idx        <= '0;
                  limit      <= LIMIT_INIT;
                  swapped    <= 1'b0;
                  o_swap_cnt <= '0;
               end
            end
            ST_SWAP: begin
               swapped <= 1'b1;
               if (o_swap_cnt != 16'hFFFF) o_swap_cnt <= o_swap_cnt + 16'd1;
            end
            ST_NEXT: begin
               if (!pass_end) begin
                  idx <= idx + AW'(1);
               end else if (!run_end) begin
                  limit   <= limit - AW'(1);
                  idx     <= '0;
                  swapped <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   // Strobes decode from state; abort masks the write and done in its own cycle.
   assign o_busy    = (state != ST_IDLE);
   assign o_rd_en   = (state == ST_READ);
   assign o_swap_we = (state == ST_SWAP) && !i_abort;
   assign o_done    = (state == ST_DONE) && !i_abort;
   assign o_addr_a  = idx;
   assign o_addr_b  = o_busy ? (idx + AW'(1)) : '0;

endmodule

// File: tb/tb_ss_sort_ctrl.sv
// Directed bench for ss_sort_ctrl with a 4-word behavioural memory datapath.
module tb_ss_sort_ctrl;

   localparam int N  = 4;
   localparam int AW = 2;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic          abort;
   logic          gt;
   logic          rd_en;
   logic [AW-1:0] addr_a;
   logic [AW-1:0] addr_b;
   logic          swap_we;
   logic          busy;
   logic          done;
   logic [15:0]   swap_cnt;

   logic [7:0] mem      [N];
   logic [7:0] init_mem [N];
   logic       load;
   logic [7:0] rd_a;
   logic [7:0] rd_b;

   int checks = 0;
   int passed = 0;
   int first_rd, done_at, rd_cnt, sw_cnt, done_cnt, ovl_cnt;

   always #5 clk = ~clk;

   ss_sort_ctrl #(.N(N), .AW(AW)) dut (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .i_start    (start),
      .i_abort    (abort),
      .i_gt       (gt),
      .o_rd_en    (rd_en),
      .o_addr_a   (addr_a),
      .o_addr_b   (addr_b),
      .o_swap_we  (swap_we),
      .o_busy     (busy),
      .o_done     (done),
      .o_swap_cnt (swap_cnt)
   );

   // Memory with one cycle of read latency; swap exchanges the addressed pair.
   always @(posedge clk) begin
      if (load) begin
         mem <= init_mem;
      end else begin
         if (rd_en) begin
            rd_a <= mem[addr_a];
            rd_b <= mem[addr_b];
         end
         if (swap_we) begin
            mem[addr_a] <= mem[addr_b];
            mem[addr_b] <= mem[addr_a];
         end
      end
   end
   assign gt = (rd_a > rd_b);

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
   endtask

   task automatic load_mem(input logic [7:0] a, b, c, d);
      init_mem[0] = a;
      init_mem[1] = b;
      init_mem[2] = c;
      init_mem[3] = d;
      load = 1'b1;
      step();
      load = 1'b0;
   endtask

   task automatic chk_sorted(input string tag);
      for (int i = 0; i < N; i++) chk(tag, 32'(mem[i]), 32'(i + 1));
   endtask

   // Pulse start, then monitor until 8 cycles past the first done (bounded).
   task automatic run(input int mid_start);
      first_rd = -1; done_at = -1;
      rd_cnt = 0; sw_cnt = 0; done_cnt = 0; ovl_cnt = 0;
      start = 1'b1;
      for (int c = 0; c < 400; c++) begin
         step();
         if (c == 0) start = 1'b0;
         if (mid_start > 0 && c == mid_start) start = 1'b1;
         if (mid_start > 0 && c == mid_start + 3) start = 1'b0;
         if (rd_en && first_rd < 0) first_rd = c;
         if (rd_en) rd_cnt++;
         if (swap_we) sw_cnt++;
         if (rd_en && swap_we) ovl_cnt++;
         if (done) begin
            done_cnt++;
            if (done_at < 0) done_at = c;
         end
         if (done_at >= 0 && c >= done_at + 8) break;
      end
      start = 1'b0;
   endtask

   task automatic chk_run(input string tag, input int rds, input int sws, input int lat,
                          input int cnt);
      chk({tag, "_first_rd"}, first_rd, 1);
      chk({tag, "_compares"}, rd_cnt, rds);
      chk({tag, "_swaps"}, sw_cnt, sws);
      chk({tag, "_done_lat"}, done_at - first_rd, lat);
      chk({tag, "_done_cnt"}, done_cnt, 1);
      chk({tag, "_overlap"}, ovl_cnt, 0);
      chk({tag, "_swap_cnt"}, 32'(swap_cnt), cnt);
      chk({tag, "_idle"}, 32'(busy), 0);
      chk_sorted({tag, "_mem"});
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; abort = 1'b0; load = 1'b0;
      step(); step();
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_rd_en", 32'(rd_en), 0);
      chk("rst_swap_we", 32'(swap_we), 0);
      chk("rst_addr_a", 32'(addr_a), 0);
      chk("rst_addr_b", 32'(addr_b), 0);
      chk("rst_swap_cnt", 32'(swap_cnt), 0);
      rst_n = 1'b1;
      step();

      // Already sorted: three compares, no swaps.
      load_mem(8'd1, 8'd2, 8'd3, 8'd4);
      run(0);
      chk_run("sorted", 3, 0, 12, 0);

      // Reversed: passes of 3, 2, 1 compares, all swapping.
      load_mem(8'd4, 8'd3, 8'd2, 8'd1);
      run(0);
      chk_run("reverse", 6, 6, 30, 6);

      // Pairwise swapped: second pass finds nothing to do.
      load_mem(8'd2, 8'd1, 8'd4, 8'd3);
      run(0);
      chk_run("pairs", 5, 2, 22, 2);

      // Second start pulse while busy is discarded.
      load_mem(8'd4, 8'd3, 8'd2, 8'd1);
      run(8);
      chk_run("restart", 6, 6, 30, 6);

      // Abort during the swap of the second compare.
      load_mem(8'd4, 8'd3, 8'd2, 8'd1);
      start = 1'b1;
      sw_cnt = 0;
      for (int c = 0; c < 100; c++) begin
         step();
         start = 1'b0;
         if (swap_we) sw_cnt++;
         if (sw_cnt == 2) break;
      end
      chk("abort_reached", sw_cnt, 2);
      abort = 1'b1;
      #1;
      chk("abort_swap_we", 32'(swap_we), 0);
      chk("abort_done", 32'(done), 0);
      step();
      abort = 1'b0;
      chk("abort_busy", 32'(busy), 0);
      chk("abort_done_next", 32'(done), 0);
      chk("abort_swap_cnt", 32'(swap_cnt), 1);
      chk("abort_mem1", 32'(mem[1]), 4);
      chk("abort_mem2", 32'(mem[2]), 2);
      run(0);
      chk_run("after_abort", 6, 5, 29, 5);

      // Abort coinciding with the start edge in IDLE wins.
      start = 1'b1;
      step();
      abort = 1'b1;
      step();
      abort = 1'b0;
      chk("abort_start_busy", 32'(busy), 0);
      step();
      chk("abort_start_busy2", 32'(busy), 0);
      start = 1'b0;
      step();

      // Reset mid-run clears outputs at once; start held across release.
      load_mem(8'd4, 8'd3, 8'd2, 8'd1);
      start = 1'b1;
      step();
      start = 1'b0;
      for (int c = 0; c < 7; c++) step();
      chk("mid_busy_before", 32'(busy), 1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_busy", 32'(busy), 0);
      chk("mid_rst_rd_en", 32'(rd_en), 0);
      chk("mid_rst_swap_we", 32'(swap_we), 0);
      chk("mid_rst_addr_a", 32'(addr_a), 0);
      chk("mid_rst_addr_b", 32'(addr_b), 0);
      chk("mid_rst_swap_cnt", 32'(swap_cnt), 0);
      start = 1'b1;
      step();
      rst_n = 1'b1;
      step();
      chk("rel_busy1", 32'(busy), 0);
      step();
      chk("rel_rd_en", 32'(rd_en), 1);
      done_cnt = 0;
      for (int c = 0; c < 400; c++) begin
         step();
         if (done) begin
            done_cnt++;
            break;
         end
      end
      start = 1'b0;
      chk("rel_done", done_cnt, 1);
      step();
      chk_sorted("rel_mem");

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/ss_sort_ctrl.md
SS_SORT_CTRL -- requirements
Module: ss_sort_ctrl

Interface
REQ-001 Parameter N, default 16: element count of the sort memory; legal range 2..256.
REQ-002 Parameter AW, default $clog2(N): address width.
REQ-003 i_clk  in  1  clock; all logic on rising edge.
REQ-004 i_rst_n  in  1  reset, asynchronous, active-low.
REQ-005 i_start  in  1  raw start level (button/host); only its rising edge is used.
REQ-006 i_abort  in  1  synchronous abort, level, active-high.
REQ-007 i_gt  in  1  datapath compare result: mem[o_addr_a] > mem[o_addr_b].
REQ-008 o_rd_en  out  1  read strobe for both addressed words.
REQ-009 o_addr_a / o_addr_b  out  AW each  compare pair idx / idx+1.
REQ-010 o_swap_we  out  1  one-cycle write strobe: datapath swaps the pair.
REQ-011 o_busy  out  1  high in every state except IDLE.
REQ-012 o_done  out  1  one-cycle pulse at normal completion.
REQ-013 o_swap_cnt  out  16  swaps performed in the current/last run, saturating.

Function
REQ-014 Start edge: i_start passes through a 2-FF edge detector; a rising edge reaches the FSM 2 cycles after i_start rises.
REQ-015 FSM states: IDLE, READ, WAIT, CMP, SWAP, NEXT, DONE; exactly one state per cycle.
REQ-016 IDLE: on start edge -> READ; idx=0, limit=N-1, swapped=0, o_swap_cnt=0.
REQ-017 READ: o_rd_en=1, o_addr_a=idx, o_addr_b=idx+1 -> WAIT.
REQ-018 WAIT: fixed 1-cycle memory latency; addresses held -> CMP.
REQ-019 CMP: sample i_gt; 1 -> SWAP, 0 -> NEXT; i_gt ignored in all other states.
REQ-020 SWAP: o_swap_we=1 for exactly one cycle, addresses held, swapped=1, o_swap_cnt+1 (saturates at 16'hFFFF) -> NEXT.
REQ-021 NEXT, idx<limit-1: idx+1 -> READ.
REQ-022 NEXT, idx==limit-1 (end of pass): if swapped==0 or limit==1 -> DONE; else limit-1, idx=0, swapped=0 -> READ.
REQ-023 DONE: o_done=1 one cycle -> IDLE; o_swap_cnt holds until next start.
REQ-024 Cycle cost: 4 cycles per non-swapping compare, 5 per swapping compare, +1 DONE.
REQ-025 Start edges while o_busy=1 are discarded, not queued.
REQ-026 i_abort=1 in any non-IDLE state -> IDLE next cycle; no o_done, no o_swap_we that cycle; o_swap_cnt holds.
REQ-027 i_abort and start edge in same IDLE cycle: abort wins, stays IDLE.
REQ-028 o_rd_en and o_swap_we are never high in the same cycle; both low outside READ/SWAP.

Reset
REQ-029 Reset asserted: state=IDLE, idx=0, limit=N-1, swapped=0, edge FFs=0, all outputs 0 (o_addr_b=0), including mid-run.
REQ-030 i_start held high across reset release produces a start edge 2 cycles after release (edge FFs reset to 0).

Structure
REQ-031 Package ss_sort_pkg holds the state enum type and the N default constant; shared with the sort datapath.
REQ-032 Start edge detection reuses SS_detect_edge with POS_EDGE=1; no other sub-module.
REQ-033 Outputs are registered or decoded from the state register only; no combinational path from i_gt to outputs.

Verification
REQ-034 N=4, data {1,2,3,4}: start -> 3 compares, 0 swaps, o_done 12 cycles after first READ, o_swap_cnt=0.
REQ-035 N=4, data {4,3,2,1}: start -> passes of 3,2,1 compares, 6 swaps, final memory {1,2,3,4}, o_swap_cnt=6, single o_done.
REQ-036 N=16 random data, 100 runs: final memory ascending, o_swap_cnt equals reference inversion count.
REQ-037 i_abort during SWAP of the 2nd compare -> IDLE next cycle, no o_done, o_busy=0, next start runs normally.
REQ-038 Second i_start pulse mid-run -> ignored, exactly one o_done; i_rst_n low mid-run -> all outputs 0 asynchronously.
